// File: rtl/ask_demod.sv
// ask_demod: ASK demodulator - rectify, integrate over SPB-sample windows, threshold to bits, lock tracking.
// Optional macro ASK_DEMOD_BYTE_EN adds dout_byte/byte_valid with an MSB-first byte assembler.
module ask_demod #(
    parameter int SPB     = 256,
    parameter int THRESH  = SPB * 32,
    parameter int DET_LVL = 16,
    parameter int LOSS_N  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_ASK,
    output logic       dout_bit,
    output logic       dout_valid,
    output logic       locked
`ifdef ASK_DEMOD_BYTE_EN
    ,
    output logic [7:0] dout_byte,
    output logic       byte_valid
`endif
);
    localparam int CW = $clog2(SPB);
    localparam int AW = CW + 8;

    typedef enum logic {SEARCH, TRACK} state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_amp;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_acc;
    logic            r_dec, r_dec_v;
    logic [3:0]      r_loss;
    logic [AW-1:0]   w_sum;
    logic            w_last, w_drop;

    assign w_sum  = r_acc + AW'(r_amp);
    assign w_last = r_cnt == CW'(SPB - 1);
    assign w_drop = r_dec_v && !r_dec && (r_loss == 4'(LOSS_N - 1));
    assign locked = r_state == TRACK;

    // Rectifier: distance of the sample from midscale.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_amp <= '0;
        else     r_amp <= din_ASK[7] ? {1'b0, din_ASK[6:0]} : 8'd128 - din_ASK;

    // State register.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= SEARCH;
        else     r_state <= w_next;

    // Acquire on a strong sample; drop lock when the LOSS_N-th consecutive zero is emitted.
    always_comb begin
        w_next = r_state;
        if (r_state == SEARCH) w_next = (32'(r_amp) >= 32'(DET_LVL)) ? TRACK : SEARCH;
        else if (w_drop)       w_next = SEARCH;
    end

    // Window integrator: the acquiring sample is sample 0; the window's final sum is decided without dropping the next sample.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dec   <= 1'b0;
            r_dec_v <= 1'b0;
        end else if (w_next == SEARCH) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dec_v <= 1'b0;
        end else begin
            r_dec_v <= w_last;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_dec <= 32'(w_sum) >= 32'(THRESH);
                r_acc <= '0;
            end else
                r_acc <= w_sum;
        end

    // Bit output and consecutive-zero counter.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dout_bit   <= 1'b0;
            dout_valid <= 1'b0;
            r_loss     <= '0;
        end else begin
            dout_valid <= r_dec_v;
            if (r_dec_v) begin
                dout_bit <= r_dec;
                r_loss   <= (r_dec || w_drop) ? 4'd0 : r_loss + 4'd1;
            end
        end

`ifdef ASK_DEMOD_BYTE_EN
    logic [6:0] r_sh;
    logic [2:0] r_bcnt;

    // Byte assembler: every 8th decided bit since acquisition completes an MSB-first byte.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_sh       <= '0;
            r_bcnt     <= '0;
            dout_byte  <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= r_dec_v && r_bcnt == 3'd7;
            if (r_dec_v) r_sh <= {r_sh[5:0], r_dec};
            if (r_dec_v && r_bcnt == 3'd7) dout_byte <= {r_sh, r_dec};
            r_bcnt <= (w_next == SEARCH) ? 3'd0 : r_bcnt + 3'(r_dec_v);
        end
`endif
endmodule
